// File: rtl/ocp_pkg.sv
// Shared encodings and helpers for the OCP command router.
package ocp_pkg;

  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_WR   = 3'b001;
  localparam logic [2:0] MCMD_RD   = 3'b010;

  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_ERR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMD  = 2'b01,
    ST_WAIT = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/ocp_router_timer.sv
// Transaction watchdog: clear on state entry, count while busy,
// flag the last allowed cycle.
module ocp_router_timer
  import ocp_pkg::*;
#(
  parameter int TO_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int TOW = clog2(TO_CYC);
  localparam logic [TOW-1:0] LAST = TOW'(TO_CYC - 1);

  logic [TOW-1:0] cnt;

  assign expired = inc && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ocp_router.sv
// Single-master, multi-slave OCP command router with hole/illegal
// command errors, per-transaction timeout and saturating error count.
module ocp_router
  import ocp_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int SELW = 2,
  parameter logic [(2**SELW)-1:0] REGION_EN = '1,
  parameter int TO_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               m_MCmd,
  input  logic [AW-1:0]            m_MAddr,
  input  logic [DW-1:0]            m_MData,
  output logic                     m_SCmdAccept,
  output logic [1:0]               m_SResp,
  output logic [DW-1:0]            m_SData,
  output logic [3*(2**SELW)-1:0]   s_MCmd,
  output logic [AW-1:0]            s_MAddr,
  output logic [DW-1:0]            s_MData,
  input  logic [(2**SELW)-1:0]     s_SCmdAccept,
  input  logic [2*(2**SELW)-1:0]   s_SResp,
  input  logic [DW*(2**SELW)-1:0]  s_SData,
  input  logic                     err_clr,
  output logic [SELW-1:0]          active_sel,
  output logic [1:0]               link_state,
  output logic [7:0]               err_cnt
);

  state_t          state, state_d;
  logic [2:0]      cmd_q;
  logic [SELW-1:0] sel_q;
  logic [SELW-1:0] m_sel;
  logic [1:0]      resp_d;
  logic [DW-1:0]   data_d;
  logic            err_evt, tmr_clr, tmr_inc, tmr_exp;
  logic            cap, legal, mapped;
  logic            acc;
  logic [1:0]      rsp;
  logic [DW-1:0]   rdat;
  int              sel_i;

  assign m_sel  = m_MAddr[AW-1 -: SELW];
  assign legal  = (m_MCmd == MCMD_WR) || (m_MCmd == MCMD_RD);
  assign mapped = REGION_EN[m_sel];
  assign cap    = (state == ST_IDLE) && (m_MCmd != MCMD_IDLE);

  assign sel_i = int'(sel_q);
  assign acc   = s_SCmdAccept[sel_q];
  assign rsp   = s_SResp[2*sel_i +: 2];
  assign rdat  = s_SData[DW*sel_i +: DW];

  assign m_SCmdAccept = (state == ST_IDLE);
  assign active_sel   = sel_q;
  assign link_state   = state;
  assign tmr_inc      = (state == ST_CMD) || (state == ST_WAIT);

  ocp_router_timer #(
    .TO_CYC (TO_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_exp)
  );

  always_comb begin
    s_MCmd = '0;
    if (state == ST_CMD) s_MCmd[3*sel_i +: 3] = cmd_q;
  end

  // A slave accept/response in the expiry cycle takes priority.
  always_comb begin
    state_d = state;
    resp_d  = SRESP_NULL;
    data_d  = '0;
    err_evt = 1'b0;
    tmr_clr = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cap) begin
          if (legal && mapped) begin
            state_d = ST_CMD;
            tmr_clr = 1'b1;
          end else begin
            resp_d  = SRESP_ERR;
            err_evt = 1'b1;
          end
        end
      end
      ST_CMD: begin
        if (acc) begin
          state_d = ST_WAIT;
          tmr_clr = 1'b1;
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
          resp_d  = SRESP_ERR;
          err_evt = 1'b1;
        end
      end
      ST_WAIT: begin
        if (rsp != SRESP_NULL) begin
          state_d = ST_IDLE;
          resp_d  = rsp;
          data_d  = rdat;
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
          resp_d  = SRESP_ERR;
          err_evt = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cmd_q   <= '0;
      sel_q   <= '0;
      s_MAddr <= '0;
      s_MData <= '0;
      m_SResp <= SRESP_NULL;
      m_SData <= '0;
      err_cnt <= '0;
    end else begin
      state   <= state_d;
      m_SResp <= resp_d;
      m_SData <= data_d;
      if (cap) begin
        cmd_q   <= m_MCmd;
        sel_q   <= m_sel;
        s_MAddr <= m_MAddr;
        s_MData <= m_MData;
      end
      if (err_clr) begin
        err_cnt <= err_evt ? 8'd1 : 8'd0;
      end else if (err_evt && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ocp_router.sv
// Directed bench for ocp_router: vector table for error captures,
// hand-written sequences for handshakes, timeout and reset.
module tb_ocp_router;
  import ocp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  m_MCmd;
  logic [7:0]  m_MAddr, m_MData;
  logic        m_SCmdAccept;
  logic [1:0]  m_SResp;
  logic [7:0]  m_SData;
  logic [11:0] s_MCmd;
  logic [7:0]  s_MAddr, s_MData;
  logic [3:0]  s_SCmdAccept;
  logic [7:0]  s_SResp;
  logic [31:0] s_SData;
  logic        err_clr;
  logic [1:0]  active_sel, link_state;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;
  logic [11:0] stray = '0;

  always #5 clk = ~clk;

  ocp_router #(
    .AW(8), .DW(8), .SELW(2), .REGION_EN(4'b1011), .TO_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_MCmd(m_MCmd), .m_MAddr(m_MAddr), .m_MData(m_MData),
    .m_SCmdAccept(m_SCmdAccept), .m_SResp(m_SResp), .m_SData(m_SData),
    .s_MCmd(s_MCmd), .s_MAddr(s_MAddr), .s_MData(s_MData),
    .s_SCmdAccept(s_SCmdAccept), .s_SResp(s_SResp), .s_SData(s_SData),
    .err_clr(err_clr), .active_sel(active_sel),
    .link_state(link_state), .err_cnt(err_cnt)
  );

  // Any command on a slice other than slave 1 before the region-0 tests.
  always @(negedge clk) stray <= stray | (s_MCmd & ~12'h038);

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] addr;
    logic [1:0] sel;
    logic [7:0] cnt;
  } vec_t;

  vec_t v[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    v[0] = '{3'b001, 8'h80, 2'd2, 8'd1};
    v[1] = '{3'b010, 8'hBF, 2'd2, 8'd2};
    v[2] = '{3'b011, 8'h45, 2'd1, 8'd3};
    v[3] = '{3'b111, 8'h00, 2'd0, 8'd4};
    v[4] = '{3'b100, 8'hC3, 2'd3, 8'd5};

    rst_n = 1'b0;
    m_MCmd = 3'b000; m_MAddr = 8'h00; m_MData = 8'h00;
    s_SCmdAccept = 4'b0; s_SResp = 8'h00; s_SData = 32'h0;
    err_clr = 1'b0;
    ticks(2);
    chk("rst_accept", m_SCmdAccept, 1);
    chk("rst_resp", m_SResp, 0);
    chk("rst_data", m_SData, 0);
    chk("rst_scmd", s_MCmd, 0);
    chk("rst_saddr", s_MAddr, 0);
    chk("rst_state", link_state, 0);
    chk("rst_sel", active_sel, 0);
    chk("rst_err", err_cnt, 0);
    rst_n = 1'b1;
    tick();

    // RD 0x45: accept after 2 cycles, DVA 0xA5 after 3 more
    m_MCmd = 3'b010; m_MAddr = 8'h45;
    s_SResp = 8'h01;
    tick();
    m_MCmd = 3'b000;
    chk("rd_state_cmd", link_state, 1);
    chk("rd_scmd", s_MCmd, 12'h010);
    chk("rd_accept0", m_SCmdAccept, 0);
    chk("rd_sel", active_sel, 1);
    chk("rd_saddr", s_MAddr, 8'h45);
    tick();
    chk("rd_hold_cmd", s_MCmd, 12'h010);
    chk("rd_no_resp", m_SResp, 0);
    s_SCmdAccept = 4'b0010;
    tick();
    s_SCmdAccept = 4'b0;
    chk("rd_state_wait", link_state, 2);
    chk("rd_scmd_drop", s_MCmd, 0);
    ticks(2);
    chk("rd_wait_resp", m_SResp, 0);
    s_SResp = 8'h04; s_SData = 32'h0000_A500;
    tick();
    s_SResp = 8'h00; s_SData = 32'h0;
    chk("rd_resp", m_SResp, 1);
    chk("rd_data", m_SData, 8'hA5);
    chk("rd_accept1", m_SCmdAccept, 1);
    tick();
    chk("rd_resp_once", m_SResp, 0);
    chk("rd_no_stray", stray, 0);

    // Hole / unsupported commands, back to back
    for (int i = 0; i < 5; i++) begin
      m_MCmd = v[i].cmd; m_MAddr = v[i].addr; m_MData = 8'(8'h10 + i);
      tick();
      chk($sformatf("vec%0d_resp", i), m_SResp, 2'b11);
      chk($sformatf("vec%0d_data", i), m_SData, 0);
      chk($sformatf("vec%0d_acc", i), m_SCmdAccept, 1);
      chk($sformatf("vec%0d_scmd", i), s_MCmd, 0);
      chk($sformatf("vec%0d_state", i), link_state, 0);
      chk($sformatf("vec%0d_sel", i), active_sel, v[i].sel);
      chk($sformatf("vec%0d_saddr", i), s_MAddr, v[i].addr);
      chk($sformatf("vec%0d_sdata", i), s_MData, 8'h10 + i);
      chk($sformatf("vec%0d_err", i), err_cnt, v[i].cnt);
    end
    m_MCmd = 3'b000;
    tick();
    chk("idle_resp", m_SResp, 0);

    // Timeout in CMD, late response ignored, then normal RD
    m_MCmd = 3'b010; m_MAddr = 8'h10;
    tick();
    m_MCmd = 3'b000;
    ticks(7);
    chk("to_still_cmd", link_state, 1);
    chk("to_scmd", s_MCmd, 12'h002);
    chk("to_no_resp", m_SResp, 0);
    tick();
    chk("to_resp", m_SResp, 2'b11);
    chk("to_data", m_SData, 0);
    chk("to_scmd_off", s_MCmd, 0);
    chk("to_state", link_state, 0);
    chk("to_err", err_cnt, 6);
    s_SResp = 8'h01; s_SData = 32'h0000_00EE;
    tick();
    s_SResp = 8'h00; s_SData = 32'h0;
    chk("late_ignored", m_SResp, 0);
    chk("late_state", link_state, 0);
    m_MCmd = 3'b010; m_MAddr = 8'h10;
    tick();
    m_MCmd = 3'b000;
    s_SCmdAccept = 4'b0001;
    tick();
    s_SCmdAccept = 4'b0;
    s_SResp = 8'h01; s_SData = 32'h0000_003C;
    tick();
    s_SResp = 8'h00; s_SData = 32'h0;
    chk("after_to_resp", m_SResp, 1);
    chk("after_to_data", m_SData, 8'h3C);

    // Accept and response both land in the expiry cycle
    m_MCmd = 3'b010; m_MAddr = 8'h20;
    tick();
    m_MCmd = 3'b000;
    ticks(7);
    s_SCmdAccept = 4'b0001;
    tick();
    s_SCmdAccept = 4'b0;
    chk("edge_acc_state", link_state, 2);
    chk("edge_acc_resp", m_SResp, 0);
    chk("edge_acc_err", err_cnt, 6);
    ticks(7);
    chk("edge_wait_state", link_state, 2);
    s_SResp = 8'h01; s_SData = 32'h0000_005A;
    tick();
    s_SResp = 8'h00; s_SData = 32'h0;
    chk("edge_rsp_resp", m_SResp, 1);
    chk("edge_rsp_data", m_SData, 8'h5A);
    chk("edge_rsp_err", err_cnt, 6);

    // Saturation and clear
    m_MCmd = 3'b001; m_MAddr = 8'h80;
    ticks(300);
    chk("sat_err", err_cnt, 255);
    err_clr = 1'b1;
    tick();
    chk("clr_with_err", err_cnt, 1);
    m_MCmd = 3'b000;
    tick();
    err_clr = 1'b0;
    chk("clr_only", err_cnt, 0);

    // Reset while waiting for a response
    m_MCmd = 3'b010; m_MAddr = 8'h45;
    tick();
    m_MCmd = 3'b000;
    s_SCmdAccept = 4'b0010;
    tick();
    s_SCmdAccept = 4'b0;
    chk("rw_state_wait", link_state, 2);
    rst_n = 1'b0;
    s_SResp = 8'h04; s_SData = 32'h0000_9900;
    tick();
    s_SResp = 8'h00; s_SData = 32'h0;
    chk("rw_resp", m_SResp, 0);
    chk("rw_data", m_SData, 0);
    chk("rw_state", link_state, 0);
    chk("rw_scmd", s_MCmd, 0);
    chk("rw_accept", m_SCmdAccept, 1);
    chk("rw_saddr", s_MAddr, 0);
    chk("rw_sel", active_sel, 0);
    rst_n = 1'b1;
    m_MCmd = 3'b010; m_MAddr = 8'h50;
    tick();
    m_MCmd = 3'b000;
    chk("post_rst_cmd", s_MCmd, 12'h010);
    s_SCmdAccept = 4'b0010;
    tick();
    s_SCmdAccept = 4'b0;
    s_SResp = 8'h04; s_SData = 32'h0000_7700;
    tick();
    s_SResp = 8'h00; s_SData = 32'h0;
    chk("post_rst_resp", m_SResp, 1);
    chk("post_rst_data", m_SData, 8'h77);
    chk("post_rst_err", err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
